// File: rtl/lcd_pixel_emitter.sv
// LCD pixel emitter: buffers PPU pixels in a 4-deep FIFO and writes them out with line/frame timing.
// Define LCD_EMITTER_UNDERFLOW_CNT_EN to add the O_UNDERFLOW_COUNT port.
module lcd_pixel_emitter #(
    parameter int HBLANK_CYCLES = 204,
    parameter int VBLANK_CYCLES = 4560
) (
    input  logic       I_GPU_CLOCK,
    input  logic       I_RESET,
    input  logic       I_LCD_ON,
    input  logic [1:0] I_PIX,
    input  logic       I_PIX_VALID,
    output logic       O_PIX_READY,
    output logic [1:0] O_PIXEL_DATA,
    output logic [7:0] O_GB_PIXEL_COUNT,
    output logic [7:0] O_GB_LINE_COUNT,
    output logic       O_GB_HSYNC,
    output logic       O_GB_VSYNC,
    output logic       O_GB_WE
`ifdef LCD_EMITTER_UNDERFLOW_CNT_EN
    ,
    output logic [7:0] O_UNDERFLOW_COUNT
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_HBLANK = 2'd2;
    localparam logic [1:0] S_VBLANK = 2'd3;

    localparam logic [15:0] HB_LAST = 16'(HBLANK_CYCLES - 1);
    localparam logic [15:0] VB_LAST = 16'(VBLANK_CYCLES - 1);

    logic [1:0]  r_state;
    logic [1:0]  r_mem [4];
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [2:0]  r_cnt;
    logic [7:0]  r_x;
    logic [7:0]  r_line;
    logic [15:0] r_blank_cnt;
    logic        r_we;
    logic        r_hsync;
    logic        r_vsync;
    logic [1:0]  r_data;
    logic [7:0]  r_pix_cnt;
    logic [7:0]  r_line_cnt;

    logic w_full;
    logic w_empty;
    logic w_ready;
    logic w_push;
    logic w_pop;
    logic w_hb_done;
    logic w_vb_entry;

    assign w_full     = (r_cnt == 3'd4);
    assign w_empty    = (r_cnt == 3'd0);
    assign w_ready    = (r_state != S_IDLE) && !w_full;
    assign w_push     = I_PIX_VALID && w_ready;
    assign w_pop      = (r_state == S_ACTIVE) && !w_empty;
    assign w_hb_done  = (r_state == S_HBLANK) && (r_blank_cnt == HB_LAST);
    assign w_vb_entry = w_hb_done && (r_line == 8'd143);

    assign O_PIX_READY      = w_ready;
    assign O_PIXEL_DATA     = r_data;
    assign O_GB_PIXEL_COUNT = r_pix_cnt;
    assign O_GB_LINE_COUNT  = r_line_cnt;
    assign O_GB_HSYNC       = r_hsync;
    assign O_GB_VSYNC       = r_vsync;
    assign O_GB_WE          = r_we;

    always_ff @(posedge I_GPU_CLOCK) begin
        if (w_push) begin
            r_mem[r_wptr] <= I_PIX;
        end
    end

    // IDLE flushes the FIFO so a restart never replays stale pixels
    always_ff @(posedge I_GPU_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            r_wptr <= 2'd0;
            r_rptr <= 2'd0;
            r_cnt  <= 3'd0;
        end else if (r_state == S_IDLE) begin
            r_wptr <= 2'd0;
            r_rptr <= 2'd0;
            r_cnt  <= 3'd0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge I_GPU_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            r_state     <= S_IDLE;
            r_x         <= 8'd0;
            r_line      <= 8'd0;
            r_blank_cnt <= 16'd0;
            r_we        <= 1'b0;
            r_hsync     <= 1'b0;
            r_vsync     <= 1'b0;
            r_data      <= 2'd0;
            r_pix_cnt   <= 8'd0;
            r_line_cnt  <= 8'd0;
        end else begin
            r_we    <= 1'b0;
            r_hsync <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_vsync     <= 1'b0;
                    r_x         <= 8'd0;
                    r_line      <= 8'd0;
                    r_blank_cnt <= 16'd0;
                    if (I_LCD_ON) begin
                        r_state <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (w_pop) begin
                        r_we       <= 1'b1;
                        r_data     <= r_mem[r_rptr];
                        r_pix_cnt  <= r_x;
                        r_line_cnt <= r_line;
                        if (r_x == 8'd159) begin
                            r_x         <= 8'd0;
                            r_hsync     <= 1'b1;
                            r_blank_cnt <= 16'd0;
                            r_state     <= S_HBLANK;
                        end else begin
                            r_x <= r_x + 8'd1;
                        end
                    end
                end
                S_HBLANK: begin
                    if (w_hb_done) begin
                        r_blank_cnt <= 16'd0;
                        r_line      <= r_line + 8'd1;
                        if (w_vb_entry) begin
                            r_vsync <= 1'b1;
                            r_state <= S_VBLANK;
                        end else begin
                            r_state <= S_ACTIVE;
                        end
                    end else begin
                        r_blank_cnt <= r_blank_cnt + 16'd1;
                    end
                end
                S_VBLANK: begin
                    if (r_blank_cnt == VB_LAST) begin
                        r_blank_cnt <= 16'd0;
                        r_vsync     <= 1'b0;
                        r_line      <= 8'd0;
                        r_state     <= I_LCD_ON ? S_ACTIVE : S_IDLE;
                    end else begin
                        r_blank_cnt <= r_blank_cnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef LCD_EMITTER_UNDERFLOW_CNT_EN
    logic [7:0] r_underflow;

    assign O_UNDERFLOW_COUNT = r_underflow;

    always_ff @(posedge I_GPU_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            r_underflow <= 8'd0;
        end else if (w_vb_entry) begin
            r_underflow <= 8'd0;
        end else if ((r_state == S_ACTIVE) && w_empty && (r_underflow != 8'hFF)) begin
            r_underflow <= r_underflow + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lcd_pixel_emitter.sv
// Directed self-checking bench for lcd_pixel_emitter (short blanking for run time).
module tb_lcd_pixel_emitter;

    localparam int HB = 8;
    localparam int VB = 20;

    logic       clk = 1'b0;
    logic       I_RESET;
    logic       I_LCD_ON;
    logic [1:0] I_PIX;
    logic       I_PIX_VALID;
    logic       O_PIX_READY;
    logic [1:0] O_PIXEL_DATA;
    logic [7:0] O_GB_PIXEL_COUNT;
    logic [7:0] O_GB_LINE_COUNT;
    logic       O_GB_HSYNC;
    logic       O_GB_VSYNC;
    logic       O_GB_WE;
`ifdef LCD_EMITTER_UNDERFLOW_CNT_EN
    logic [7:0] O_UNDERFLOW_COUNT;
`endif

    lcd_pixel_emitter #(.HBLANK_CYCLES(HB), .VBLANK_CYCLES(VB)) dut (
        .I_GPU_CLOCK      (clk),
        .I_RESET          (I_RESET),
        .I_LCD_ON         (I_LCD_ON),
        .I_PIX            (I_PIX),
        .I_PIX_VALID      (I_PIX_VALID),
        .O_PIX_READY      (O_PIX_READY),
        .O_PIXEL_DATA     (O_PIXEL_DATA),
        .O_GB_PIXEL_COUNT (O_GB_PIXEL_COUNT),
        .O_GB_LINE_COUNT  (O_GB_LINE_COUNT),
        .O_GB_HSYNC       (O_GB_HSYNC),
        .O_GB_VSYNC       (O_GB_VSYNC),
        .O_GB_WE          (O_GB_WE)
`ifdef LCD_EMITTER_UNDERFLOW_CNT_EN
        ,
        .O_UNDERFLOW_COUNT(O_UNDERFLOW_COUNT)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [1:0] q[$];
    logic [1:0] pix_drv = 2'd0;
    bit   feed = 1'b0;
    bit   hs_pend = 1'b0;
    logic vs_prev = 1'b0;
    int cyc_n = 0;
    int exp_x = 0;
    int exp_line = 0;
    int hs_cnt = 0;
    int total_we = 0;
    int first_we = -1;
    int last_we_cyc = 0;
    int line_start = 0;
    int last_hs_cyc = 0;
    int stall_gap = 0;
    int vs_rises = 0;
    int vs_high = 0;
    int vs_fall_cyc = 0;
    int g;
    int r0;
    int we0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, update the model, drive the next inputs
    task automatic cyc();
        logic [1:0] e;
        @(negedge clk);
        cyc_n++;
        if (hs_pend) q.push_back(pix_drv);
        if (O_GB_WE === 1'b1) begin
            total_we++;
            chk("we_fifo_nonempty", (q.size() > 0), 1);
            e = (q.size() > 0) ? q.pop_front() : 2'd0;
            chk("we_data", O_PIXEL_DATA, e);
            chk("we_x", O_GB_PIXEL_COUNT, exp_x);
            chk("we_line", O_GB_LINE_COUNT, exp_line);
            if (first_we < 0) first_we = cyc_n;
            if (exp_x != 0 && cyc_n - last_we_cyc > 1) stall_gap = cyc_n - last_we_cyc - 1;
            if (exp_x == 0) line_start = cyc_n;
            last_we_cyc = cyc_n;
            exp_x = (exp_x == 159) ? 0 : exp_x + 1;
        end
        if (O_GB_HSYNC === 1'b1) begin
            chk("hsync_with_x159", {O_GB_WE, O_GB_PIXEL_COUNT}, {1'b1, 8'd159});
            hs_cnt++;
            last_hs_cyc = cyc_n;
            exp_line++;
        end
        if (O_GB_VSYNC === 1'b1 && vs_prev !== 1'b1) begin
            vs_rises++;
            vs_high = 0;
            chk("vsync_after_144_lines", hs_cnt, 144);
            chk("vsync_rise_timing", cyc_n - last_hs_cyc, HB);
            hs_cnt = 0;
            exp_line = 0;
        end
        if (O_GB_VSYNC === 1'b1) vs_high++;
        if (O_GB_VSYNC !== 1'b1 && vs_prev === 1'b1) vs_fall_cyc = cyc_n;
        vs_prev = O_GB_VSYNC;
        if (hs_pend) pix_drv = 2'($urandom_range(0, 3));
        I_PIX = pix_drv;
        I_PIX_VALID = feed;
        hs_pend = feed && (O_PIX_READY === 1'b1);
    endtask

    initial begin
        I_RESET = 1'b1;
        I_LCD_ON = 1'b0;
        I_PIX = 2'd0;
        I_PIX_VALID = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_we", O_GB_WE, 0);
        chk("rst_hsync", O_GB_HSYNC, 0);
        chk("rst_vsync", O_GB_VSYNC, 0);
        chk("rst_ready", O_PIX_READY, 0);
        chk("rst_counts", {O_GB_LINE_COUNT, O_GB_PIXEL_COUNT, 6'd0, O_PIXEL_DATA}, 0);

        I_RESET = 1'b0;
        I_LCD_ON = 1'b1;
        feed = 1'b1;
        I_PIX_VALID = 1'b1;
        I_PIX = pix_drv;
        hs_pend = 1'b0;

        g = 0;
        while (hs_cnt == 0 && g < 2000) begin cyc(); g++; end
        chk("first_line_done", hs_cnt, 1);
        chk("first_we_latency", first_we, 3);
        chk("line0_consecutive", last_hs_cyc - line_start, 159);
        repeat (6) cyc();
        chk("ready_low_fifo_full", O_PIX_READY, 0);
        chk("we_low_hblank", O_GB_WE, 0);
        g = 0;
        while (line_start < last_hs_cyc && g < 100) begin cyc(); g++; end
        chk("hblank_gap", line_start - last_hs_cyc, HB + 1);

        g = 0;
        while (!(exp_line == 2 && exp_x == 50) && g < 2000) begin cyc(); g++; end
        feed = 1'b0;
        I_PIX_VALID = 1'b0;
        hs_pend = 1'b0;
        repeat (9) cyc();
        chk("ready_during_stall", O_PIX_READY, 1);
        chk("we_low_during_stall", O_GB_WE, 0);
        feed = 1'b1;
        g = 0;
        while (exp_x < 60 && g < 100) begin cyc(); g++; end
        chk("stall_gap", stall_gap, 8);
`ifdef LCD_EMITTER_UNDERFLOW_CNT_EN
        chk("underflow_count", O_UNDERFLOW_COUNT, 9);
`endif

        r0 = vs_rises;
        g = 0;
        while (vs_rises == r0 && g < 30000) begin cyc(); g++; end
        chk("frame1_vsync_seen", vs_rises, r0 + 1);
`ifdef LCD_EMITTER_UNDERFLOW_CNT_EN
        chk("underflow_cleared", O_UNDERFLOW_COUNT, 0);
`endif
        g = 0;
        while (O_GB_VSYNC === 1'b1 && g < 200) begin cyc(); g++; end
        chk("vsync_high_len", vs_high, VB);
        g = 0;
        while (line_start < vs_fall_cyc && g < 100) begin cyc(); g++; end
        chk("vblank_exit_gap", line_start - vs_fall_cyc, 1);

        g = 0;
        while (exp_line < 70 && g < 30000) begin cyc(); g++; end
        I_LCD_ON = 1'b0;
        r0 = vs_rises;
        g = 0;
        while (vs_rises == r0 && g < 30000) begin cyc(); g++; end
        chk("frame2_completed", vs_rises, r0 + 1);
        g = 0;
        while (O_GB_VSYNC === 1'b1 && g < 200) begin cyc(); g++; end
        chk("frame2_vsync_len", vs_high, VB);
        repeat (3) cyc();
        we0 = total_we;
        repeat (40) cyc();
        chk("idle_no_we", total_we - we0, 0);
        chk("idle_ready", O_PIX_READY, 0);
        chk("idle_syncs", {O_GB_HSYNC, O_GB_VSYNC}, 0);
        chk("idle_hold_x", O_GB_PIXEL_COUNT, 159);
        chk("idle_hold_line", O_GB_LINE_COUNT, 143);
        q.delete();

        I_LCD_ON = 1'b1;
        exp_x = 0;
        exp_line = 0;
        r0 = vs_rises;
        g = 0;
        while (vs_rises == r0 && g < 30000) begin cyc(); g++; end
        chk("frame3_vsync_seen", vs_rises, r0 + 1);
        repeat (5) cyc();
        chk("frame3_in_vblank", O_GB_VSYNC, 1);
        I_RESET = 1'b1;
        #1;
        chk("async_rst_vsync", O_GB_VSYNC, 0);
        chk("async_rst_ready", O_PIX_READY, 0);
        chk("async_rst_outs", {O_GB_WE, O_GB_HSYNC}, 0);
        chk("async_rst_counts", {O_GB_LINE_COUNT, O_GB_PIXEL_COUNT, 6'd0, O_PIXEL_DATA}, 0);
`ifdef LCD_EMITTER_UNDERFLOW_CNT_EN
        chk("async_rst_underflow", O_UNDERFLOW_COUNT, 0);
`endif
        I_LCD_ON = 1'b0;
        @(negedge clk);
        I_RESET = 1'b0;
        q.delete();
        hs_pend = 1'b0;
        vs_prev = 1'b0;
        exp_x = 0;
        exp_line = 0;
        hs_cnt = 0;
        we0 = total_we;
        repeat (10) cyc();
        chk("post_rst_idle_ready", O_PIX_READY, 0);
        chk("post_rst_no_we", total_we - we0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
